// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide unit:
//   - ALUControl op codes, also used by the control unit (bit 0 set marks an M op)
//   - FSM state codes for muldiv_seq
//   - fixed results for the divide-by-zero and signed-overflow bypass paths
package muldiv_pkg;

  localparam int XLEN_PKG = 32;

  localparam logic [4:0] OP_MUL    = 5'b00001;
  localparam logic [4:0] OP_MULH   = 5'b00101;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01001;
  localparam logic [4:0] OP_DIV    = 5'b10001;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b11001;
  localparam logic [4:0] OP_REMU   = 5'b11101;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [31:0] DIV_BY_ZERO_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] OVERFLOW_QUO    = 32'h8000_0000;
  localparam logic [31:0] OVERFLOW_REM    = 32'h0000_0000;

  // Bit 4 separates the divide family from the multiply family.
  function automatic logic is_div_class(input logic [4:0] op);
    return op[4];
  endfunction

  // Only DIV and REM interpret their operands as two's complement.
  function automatic logic is_signed_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Bit 3 in the divide family selects the remainder as the result.
  function automatic logic is_rem(input logic [4:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/muldiv_seq_div_iter_core.sv
// div_iter_core
// Unsigned 32-step restoring divider datapath.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   load_i        capture dividend/divisor, clear remainder and step counter
//   step_i        perform one shift/subtract step
//   dividend_i    unsigned dividend (magnitude)
//   divisor_i     unsigned divisor (magnitude)
//   quotient_o    quotient register
//   remainder_o   low 32 bits of the remainder register
//   done_o        high on the step that wraps the counter 31->0 (last step)
module div_iter_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o
);

  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] shifted;

  // One restoring step: bring the next dividend bit into the remainder and
  // keep the subtraction only when it does not go negative.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q[31:0], quo_q[31]};
    if (load_i) begin
      rem_d = 33'd0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = 5'd0;
    end else if (step_i) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = shifted - {1'b0, dvs_q};
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted;
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= 33'd0;
      quo_q <= 32'd0;
      dvs_q <= 32'd0;
      cnt_q <= 5'd0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o      = step_i && (cnt_q == 5'd31);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[31:0];

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Multi-cycle RV32M execution unit: single registered-cycle multiply and a
// 32-step restoring divide with sign fix-up.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start_i      request, taken only when ready_o=1 and op_i[0]=1
//   op_i         ALUControl op code (see muldiv_pkg)
//   a_i, b_i     rs1 / rs2 operands
//   flush_i      abort the in-flight op (no result, result_o kept)
//   ready_o      high only in IDLE
//   valid_o      one-cycle completion pulse
//   result_o     last completed result
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  logic [2:0]  state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;

  logic        accept;
  logic        in_signed;
  logic [31:0] mag_a, mag_b;
  logic        div_step, div_done;
  logic [31:0] div_quo, div_rem;

  logic        mul_sa, mul_sb;
  logic [63:0] mul_a64, mul_b64, mul_prod;
  logic [31:0] mul_res;

  logic        fix_sa, fix_sb;
  logic [31:0] fix_quo, fix_rem, fix_res;

  // Flush in IDLE takes priority over a request.
  assign accept    = (state_q == ST_IDLE) && start_i && op_i[0] && !flush_i;
  assign in_signed = is_signed_div(op_i);

  // Magnitudes for the divider; -0x80000000 wraps to itself, which is the
  // correct unsigned magnitude.
  assign mag_a = (in_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
  assign mag_b = (in_signed && b_i[31]) ? (32'd0 - b_i) : b_i;

  assign div_step = (state_q == ST_DIV);

  div_iter_core u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .step_i      (div_step),
    .dividend_i  (mag_a),
    .divisor_i   (mag_b),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  // Multiplier: operands extended to 64 bits by the op's signedness; the
  // low 64 bits of the product match the truncated 66-bit signed product.
  always_comb begin
    mul_sa   = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    mul_sb   = (op_q == OP_MULH);
    mul_a64  = {{32{mul_sa & a_q[31]}}, a_q};
    mul_b64  = {{32{mul_sb & b_q[31]}}, b_q};
    mul_prod = mul_a64 * mul_b64;
    mul_res  = (op_q == OP_MUL) ? mul_prod[31:0] : mul_prod[63:32];
  end

  // Sign fix-up: quotient sign is the xor of operand signs, remainder
  // follows the dividend.
  always_comb begin
    fix_sa  = is_signed_div(op_q) && a_q[31];
    fix_sb  = is_signed_div(op_q) && b_q[31];
    fix_quo = (fix_sa ^ fix_sb) ? (32'd0 - div_quo) : div_quo;
    fix_rem = fix_sa ? (32'd0 - div_rem) : div_rem;
    fix_res = is_rem(op_q) ? fix_rem : fix_quo;
  end

  // Control FSM; a flush outside IDLE discards any completion this cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = op_i;
          a_d  = a_i;
          b_d  = b_i;
          if (!is_div_class(op_i)) begin
            state_d = ST_MUL;
          end else if (b_i == 32'd0) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = is_rem(op_i) ? a_i : DIV_BY_ZERO_QUO;
          end else if (in_signed && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = is_rem(op_i) ? OVERFLOW_REM : OVERFLOW_QUO;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        state_d  = ST_DONE;
        valid_d  = 1'b1;
        result_d = mul_res;
      end
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d  = ST_DONE;
        valid_d  = 1'b1;
        result_d = fix_res;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush_i && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  // A flush arriving in DONE also suppresses the pulse already on its way out.
  assign valid_o  = valid_q && !flush_i;
  assign result_o = result_q;

endmodule
